// File: rtl/pf_dpsram_pkg.sv
// Shared constants and helpers for the parametrised true dual-port SRAM.
// The merge helper works on a fixed maximum width; callers zero-extend and truncate.
package pf_dpsram_pkg;

   localparam int WM_NO_CHANGE   = 0;
   localparam int WM_READ_FIRST  = 1;
   localparam int WM_WRITE_FIRST = 2;

   localparam int MERGE_W = 512;

   // Lane i of the result is new_data when lane_en[i] is set, otherwise old_word.
   function automatic logic [MERGE_W-1:0] byte_merge(
      input logic [MERGE_W-1:0] old_word,
      input logic [MERGE_W-1:0] new_data,
      input logic [MERGE_W-1:0] lane_en,
      input int                 byte_width
   );
      logic [MERGE_W-1:0] merged;
      logic [MERGE_W-1:0] lane_mask;
      logic [MERGE_W-1:0] en;
      merged    = old_word;
      lane_mask = ~({MERGE_W{1'b1}} << byte_width);
      en        = lane_en;
      if (byte_width > 0) begin
         for (int l = 0; l < MERGE_W / byte_width; l++) begin
            if (en[0]) merged = (merged & ~lane_mask) | (new_data & lane_mask);
            lane_mask = lane_mask << byte_width;
            en        = en >> 1;
         end
      end
      return merged;
   endfunction

   function automatic bit params_ok(input int data_width, input int byte_width,
                                    input int read_latency, input int write_mode);
      return (byte_width > 0) && (data_width > 0) && (data_width <= MERGE_W) &&
             (data_width % byte_width == 0) &&
             (read_latency == 1 || read_latency == 2) &&
             (write_mode >= WM_NO_CHANGE && write_mode <= WM_WRITE_FIRST);
   endfunction

endpackage

// File: rtl/pf_dpsram_out_pipe.sv
// Per-port read-data/valid pipeline, one or two register stages deep.
// dout only changes on a valid update and holds otherwise.
module pf_dpsram_out_pipe #(
   parameter int DATA_WIDTH   = 20,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid
);

   logic                  s1_valid;
   logic [DATA_WIDTH-1:0] s1_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
      end else begin
         s1_valid <= in_valid;
         if (in_valid) s1_data <= in_data;
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            dout_valid <= 1'b0;
            dout       <= '0;
         end else begin
            dout_valid <= s1_valid;
            if (s1_valid) dout <= s1_data;
         end
      end
   end else begin : g_lat1
      assign dout       = s1_data;
      assign dout_valid = s1_valid;
   end

endmodule

// File: rtl/pf_dpsram_param.sv
// Parametrised true dual-port SRAM: byte-lane writes, latency 1/2, selectable
// same-port write mode, and A-wins-per-lane resolution on write/write collisions.
module pf_dpsram_param
   import pf_dpsram_pkg::*;
#(
   parameter int DATA_WIDTH   = 20,
   parameter int BYTE_WIDTH   = 10,
   parameter int ADDR_WIDTH   = 6,
   parameter int READ_LATENCY = 1,
   parameter int WRITE_MODE   = 0,
   localparam int NUM_BYTES   = DATA_WIDTH / BYTE_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic [ADDR_WIDTH-1:0] A_ADDR,
   input  logic                  A_BLK_EN,
   input  logic                  A_WEN,
   input  logic [NUM_BYTES-1:0]  A_WBYTE_EN,
   input  logic [DATA_WIDTH-1:0] A_DIN,
   output logic [DATA_WIDTH-1:0] A_DOUT,
   output logic                  A_DOUT_VALID,
   input  logic [ADDR_WIDTH-1:0] B_ADDR,
   input  logic                  B_BLK_EN,
   input  logic                  B_WEN,
   input  logic [NUM_BYTES-1:0]  B_WBYTE_EN,
   input  logic [DATA_WIDTH-1:0] B_DIN,
   output logic [DATA_WIDTH-1:0] B_DOUT,
   output logic                  B_DOUT_VALID,
   output logic                  COLLISION
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   if (!params_ok(DATA_WIDTH, BYTE_WIDTH, READ_LATENCY, WRITE_MODE)) begin : g_param_check
      $error("pf_dpsram_param: illegal DATA_WIDTH/BYTE_WIDTH/READ_LATENCY/WRITE_MODE");
   end

   function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_word,
                                                   input logic [DATA_WIDTH-1:0] new_data,
                                                   input logic [NUM_BYTES-1:0]  lanes);
      return DATA_WIDTH'(byte_merge(MERGE_W'(old_word), MERGE_W'(new_data),
                                    MERGE_W'(lanes), BYTE_WIDTH));
   endfunction

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  a_wr, b_wr, same_addr, collision_next;
   logic [NUM_BYTES-1:0]  a_lanes, b_lanes;
   logic [DATA_WIDTH-1:0] a_old, b_old, a_final, b_final;
   logic [DATA_WIDTH-1:0] a_resp, b_resp;
   logic                  a_resp_valid, b_resp_valid;

   always_comb begin
      a_wr      = RESET_N && A_BLK_EN && A_WEN;
      b_wr      = RESET_N && B_BLK_EN && B_WEN;
      a_lanes   = a_wr ? A_WBYTE_EN : '0;
      b_lanes   = b_wr ? B_WBYTE_EN : '0;
      same_addr = (A_ADDR == B_ADDR);
      a_old     = mem[A_ADDR];
      b_old     = mem[B_ADDR];
      // On a shared address B's lanes are applied first so A overrides any lane both enable.
      a_final   = merge(same_addr ? merge(a_old, B_DIN, b_lanes) : a_old, A_DIN, a_lanes);
      b_final   = same_addr ? a_final : merge(b_old, B_DIN, b_lanes);

      a_resp_valid = A_BLK_EN && (!A_WEN || WRITE_MODE != WM_NO_CHANGE);
      b_resp_valid = B_BLK_EN && (!B_WEN || WRITE_MODE != WM_NO_CHANGE);
      a_resp       = (A_WEN && WRITE_MODE == WM_WRITE_FIRST) ? a_final : a_old;
      b_resp       = (B_WEN && WRITE_MODE == WM_WRITE_FIRST) ? b_final : b_old;

      collision_next = A_BLK_EN && B_BLK_EN && same_addr && (A_WEN || B_WEN);
   end

   always_ff @(posedge CLK) begin
      if (a_wr) mem[A_ADDR] <= a_final;
      if (b_wr && !(a_wr && same_addr)) mem[B_ADDR] <= b_final;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) COLLISION <= 1'b0;
      else          COLLISION <= collision_next;
   end

   // DOUT_VALID is a one-cycle qualifier with no back-pressure: the consumer must take DOUT that cycle.
   pf_dpsram_out_pipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY)) u_pipe_a (
      .clk(CLK), .rst_n(RESET_N), .in_valid(a_resp_valid), .in_data(a_resp),
      .dout(A_DOUT), .dout_valid(A_DOUT_VALID)
   );

   pf_dpsram_out_pipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY)) u_pipe_b (
      .clk(CLK), .rst_n(RESET_N), .in_valid(b_resp_valid), .in_data(b_resp),
      .dout(B_DOUT), .dout_valid(B_DOUT_VALID)
   );

endmodule

// File: tb/tb_pf_dpsram_param.sv
// Bench for pf_dpsram_param: four instances (RL1/NO_CHANGE and RL2 in each write mode)
// share one stimulus stream and are compared against a word/lane-level memory model.
module tb_pf_dpsram_param;

   localparam int DW = 20;
   localparam int BW = 10;
   localparam int AW = 6;
   localparam int NB = DW / BW;
   localparam int NI = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [AW-1:0] a_addr, b_addr;
   logic          a_en, a_we, b_en, b_we;
   logic [NB-1:0] a_be, b_be;
   logic [DW-1:0] a_din, b_din;

   logic [DW-1:0] a_dout [NI];
   logic [DW-1:0] b_dout [NI];
   logic          a_dv [NI];
   logic          b_dv [NI];
   logic          coll [NI];

   always #5 clk = ~clk;

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 2;
   endfunction

   function automatic int mode_of(input int k);
      return (k == 0) ? 0 : k - 1;
   endfunction

   for (genvar k = 0; k < NI; k++) begin : g_dut
      pf_dpsram_param #(
         .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW),
         .READ_LATENCY((k == 0) ? 1 : 2), .WRITE_MODE((k == 0) ? 0 : k - 1)
      ) u_dut (
         .CLK(clk), .RESET_N(rst_n),
         .A_ADDR(a_addr), .A_BLK_EN(a_en), .A_WEN(a_we), .A_WBYTE_EN(a_be), .A_DIN(a_din),
         .A_DOUT(a_dout[k]), .A_DOUT_VALID(a_dv[k]),
         .B_ADDR(b_addr), .B_BLK_EN(b_en), .B_WEN(b_we), .B_WBYTE_EN(b_be), .B_DIN(b_din),
         .B_DOUT(b_dout[k]), .B_DOUT_VALID(b_dv[k]),
         .COLLISION(coll[k])
      );
   end

   // ---------------- scoreboard ----------------
   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b1;

   logic [DW-1:0] mm [2**AW];
   logic [DW:0]   exp_q [NI*2][$];
   logic [DW-1:0] held [NI*2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         if (failures <= 40) $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW:0] resp(input logic en, input logic we, input logic [DW-1:0] old_w,
                                        input logic [DW-1:0] new_w, input int mode);
      if (!en)       return '0;
      if (!we)       return {1'b1, old_w};
      if (mode == 0) return '0;
      if (mode == 1) return {1'b1, old_w};
      return {1'b1, new_w};
   endfunction

   task automatic flush_model();
      for (int i = 0; i < NI*2; i++) begin
         exp_q[i].delete();
         held[i] = '0;
         for (int j = 0; j < lat_of(i / 2) - 1; j++) exp_q[i].push_back('0);
      end
   endtask

   // One clock cycle with the given port activity; then every output is compared.
   task automatic drive(input logic ae, input logic awe, input logic [NB-1:0] abe,
                        input logic [AW-1:0] aad, input logic [DW-1:0] ad,
                        input logic bee, input logic bwe, input logic [NB-1:0] bbe,
                        input logic [AW-1:0] bad, input logic [DW-1:0] bd);
      logic [DW-1:0] old_a, old_b, new_a, new_b, got_d;
      logic [DW:0]   e;
      logic          exp_coll, got_v;
      a_en = ae; a_we = awe; a_be = abe; a_addr = aad; a_din = ad;
      b_en = bee; b_we = bwe; b_be = bbe; b_addr = bad; b_din = bd;
      old_a = mm[aad];
      old_b = mm[bad];
      for (int l = 0; l < NB; l++)
         if (bee && bwe && bbe[l]) mm[bad][l*BW +: BW] = bd[l*BW +: BW];
      for (int l = 0; l < NB; l++)
         if (ae && awe && abe[l]) mm[aad][l*BW +: BW] = ad[l*BW +: BW];
      new_a = mm[aad];
      new_b = mm[bad];
      for (int k = 0; k < NI; k++) begin
         exp_q[2*k].push_back(resp(ae, awe, old_a, new_a, mode_of(k)));
         exp_q[2*k+1].push_back(resp(bee, bwe, old_b, new_b, mode_of(k)));
      end
      exp_coll = ae && bee && (aad == bad) && (awe || bwe);
      @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) begin
         for (int p = 0; p < 2; p++) begin
            e = exp_q[2*k+p].pop_front();
            if (e[DW]) held[2*k+p] = e[DW-1:0];
            got_v = (p == 0) ? a_dv[k] : b_dv[k];
            got_d = (p == 0) ? a_dout[k] : b_dout[k];
            if (chk_en) begin
               check($sformatf("valid_i%0d_p%0d", k, p), 32'(got_v), 32'(e[DW]));
               check($sformatf("dout_i%0d_p%0d", k, p), 32'(got_d), 32'(held[2*k+p]));
            end
         end
         if (chk_en) check($sformatf("collision_i%0d", k), 32'(coll[k]), 32'(exp_coll));
      end
   endtask

   task automatic idle();
      drive(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
   endtask

   task automatic apply_reset(input int ncyc);
      a_en = 0; a_we = 0; b_en = 0; b_we = 0;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < NI; k++) begin
         check($sformatf("rst_a_dout_i%0d", k), 32'(a_dout[k]), 32'd0);
         check($sformatf("rst_a_valid_i%0d", k), 32'(a_dv[k]), 32'd0);
         check($sformatf("rst_b_dout_i%0d", k), 32'(b_dout[k]), 32'd0);
         check($sformatf("rst_b_valid_i%0d", k), 32'(b_dv[k]), 32'd0);
         check($sformatf("rst_coll_i%0d", k), 32'(coll[k]), 32'd0);
      end
      flush_model();
      repeat (ncyc) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      a_en = 0; a_we = 0; a_be = '0; a_addr = '0; a_din = '0;
      b_en = 0; b_we = 0; b_be = '0; b_addr = '0; b_din = '0;
      #2;
      apply_reset(2);

      // Fill every word so later comparisons never see uninitialised storage.
      chk_en = 1'b0;
      for (int i = 0; i < 2**(AW-1); i++)
         drive(1, 1, '1, AW'(2*i), DW'($urandom), 1, 1, '1, AW'(2*i+1), DW'($urandom));
      apply_reset(1);
      chk_en = 1'b1;

      // Full write then read back on A.
      drive(1, 1, 2'b11, 6'd5, 20'h12345, 0, 0, '0, '0, '0);
      drive(1, 0, '0, 6'd5, '0, 0, 0, '0, '0, '0);
      check("wr_rd_dout", 32'(a_dout[0]), 32'h12345);
      check("wr_rd_valid", 32'(a_dv[0]), 32'd1);

      // Lane-0-only write from B.
      drive(0, 0, '0, '0, '0, 1, 1, 2'b01, 6'd5, 20'hFFFFF);
      drive(1, 0, '0, 6'd5, '0, 0, 0, '0, '0, '0);
      check("partial_wr", 32'(a_dout[0]), 32'h123FF);

      // A writes while B reads the same word: B sees the old word.
      drive(1, 1, 2'b11, 6'd9, 20'h00AAA, 0, 0, '0, '0, '0);
      drive(1, 1, 2'b11, 6'd9, 20'h55555, 1, 0, '0, 6'd9, '0);
      check("xport_b_old", 32'(b_dout[0]), 32'h00AAA);
      check("xport_coll", 32'(coll[0]), 32'd1);
      idle();
      check("xport_coll_pulse", 32'(coll[0]), 32'd0);
      drive(1, 0, '0, 6'd9, '0, 0, 0, '0, '0, '0);
      check("xport_new", 32'(a_dout[0]), 32'h55555);

      // Write/write on the same word, A owns lane 1 only.
      drive(1, 1, 2'b10, 6'd3, 20'h11111, 1, 1, 2'b11, 6'd3, 20'h22222);
      check("ww_coll", 32'(coll[0]), 32'd1);
      drive(1, 0, '0, 6'd3, '0, 0, 0, '0, '0, '0);
      check("ww_merge", 32'(a_dout[0]), 32'h11222);

      // Write-mode sweep on the latency-2 instances.
      drive(1, 1, 2'b11, 6'd12, 20'h00001, 0, 0, '0, '0, '0);
      idle();
      idle();
      drive(1, 1, 2'b11, 6'd12, 20'h0F0F0, 0, 0, '0, '0, '0);
      check("wm_rf_early", 32'(a_dv[2]), 32'd0);
      check("wm_wf_early", 32'(a_dv[3]), 32'd0);
      idle();
      check("wm_nc_valid", 32'(a_dv[1]), 32'd0);
      check("wm_rf_valid", 32'(a_dv[2]), 32'd1);
      check("wm_rf_dout", 32'(a_dout[2]), 32'h00001);
      check("wm_wf_valid", 32'(a_dv[3]), 32'd1);
      check("wm_wf_dout", 32'(a_dout[3]), 32'h0F0F0);

      // Reset one cycle after a latency-2 read: the pending pulse must vanish.
      drive(1, 0, '0, 6'd12, '0, 0, 0, '0, '0, '0);
      apply_reset(2);
      idle();
      idle();
      idle();
      drive(1, 0, '0, 6'd12, '0, 1, 0, '0, 6'd3, '0);
      check("rst_keep_a", 32'(a_dout[0]), 32'h0F0F0);
      check("rst_keep_b", 32'(b_dout[0]), 32'h11222);

      // Random traffic on a narrow address window to provoke collisions.
      for (int n = 0; n < 1000; n++)
         drive(1'($urandom), 1'($urandom), NB'($urandom), AW'($urandom_range(0, 7)), DW'($urandom),
               1'($urandom), 1'($urandom), NB'($urandom), AW'($urandom_range(0, 7)), DW'($urandom));

      repeat (3) idle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
